// File: rtl/order_pkg.sv
// Shared constants and state type for the 25-word window sort sequencer.
package order_pkg;

    localparam int NWIN    = 25;
    localparam int MED_IDX = 12;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } state_e;

endpackage

// File: rtl/order_seq_fifo.sv
// Result FIFO for the window sequencer: head word and count come straight
// from registers, flush empties it synchronously.
module order_seq_fifo #(
    parameter int  DSIZE  = 8,
    parameter int  FDEPTH = 4,
    localparam int AW     = $clog2(FDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic             not_empty,
    output logic [DSIZE-1:0] head,
    output logic [CW-1:0]    count
);

    logic [DSIZE-1:0] mem_q [FDEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared only on reset so the head reads 0 out of reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign not_empty = (count_q != '0);

endmodule

// File: rtl/order_25d_seq.sv
// Window sequencer for the 5x5 sort datapath: loads 25 samples, launches the
// datapath under FIFO credit and queues results. ORDER_SEQ_STAT_EN adds counters.
module order_25d_seq
    import order_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int LAT    = 6,
    parameter int FDEPTH = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DSIZE-1:0]      in_data,
    output logic                  sort_vld,
    output logic [NWIN*DSIZE-1:0] sort_data,
    input  logic [DSIZE-1:0]      sort_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DSIZE-1:0]      out_data,
    output logic                  busy
`ifdef ORDER_SEQ_STAT_EN
    ,
    output logic [15:0]           win_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int CW = $clog2(FDEPTH) + 1;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NWIN*DSIZE-1:0]   win_q, win_d;
    logic [LAT-1:0]          vchain_q, vchain_d, vchain_shift;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_not_empty;
    logic                    credit_ok;
    logic                    launch;
    logic                    capture;

    // Credits cover both results still in the datapath and results parked in the FIFO.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(FDEPTH);
    assign capture   = vchain_q[LAT-1];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        win_d    = win_q;
        in_ready = 1'b0;
        sort_vld = 1'b0;
        launch   = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    win_d[int'(idx_q)*DSIZE +: DSIZE] = in_data;
                    if (idx_q == IDX_W'(NWIN-1)) begin
                        state_d = WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (credit_ok) begin
                    state_d = FIRE;
                    launch  = 1'b1;
                end
            end
            FIRE: begin
                sort_vld = 1'b1;
                state_d  = LOAD;
            end
            default: state_d = LOAD;
        endcase
        if (clr) begin
            state_d = LOAD;
            idx_d   = '0;
            win_d   = win_q;
            launch  = 1'b0;
        end
    end

    generate
        if (LAT == 1) begin : g_chain_one
            assign vchain_shift = sort_vld;
        end else begin : g_chain_many
            assign vchain_shift = {vchain_q[LAT-2:0], sort_vld};
        end
    endgenerate

    always_comb begin
        vchain_d   = clr ? '0 : vchain_shift;
        inflight_d = clr ? '0 : (inflight_q + CW'(launch) - CW'(capture));
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            win_q      <= '0;
            vchain_q   <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            win_q      <= win_d;
            vchain_q   <= vchain_d;
            inflight_q <= inflight_d;
        end
    end

    order_seq_fifo #(
        .DSIZE  (DSIZE),
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .flush     (clr),
        .push      (capture),
        .push_data (sort_res),
        .pop       (out_ready),
        .not_empty (fifo_not_empty),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign sort_data = win_q;
    assign out_valid = fifo_not_empty;
    assign busy      = (state_q != LOAD) || (idx_q != '0) || (inflight_q != '0) || fifo_not_empty;

`ifdef ORDER_SEQ_STAT_EN
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // win_cnt wraps; stall_cnt saturates.
    always_comb begin
        win_cnt_d   = win_cnt_q + 16'(out_valid && out_ready);
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WAIT) && !credit_ok && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (clr) begin
            win_cnt_d   = '0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign win_cnt   = win_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_order_25d_seq.sv
// Randomised bench for order_25d_seq: window/credit/FIFO reference model
// checked every cycle, plus directed timing, clr and async-reset scenarios.
module tb_order_25d_seq;
    import order_pkg::*;

    localparam int DSIZE  = 8;
    localparam int LAT    = 6;
    localparam int FDEPTH = 4;

    logic                  clock = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  clr = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DSIZE-1:0]      in_data = '0;
    logic                  sort_vld;
    logic [NWIN*DSIZE-1:0] sort_data;
    logic [DSIZE-1:0]      sort_res = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DSIZE-1:0]      out_data;
    logic                  busy;
`ifdef ORDER_SEQ_STAT_EN
    logic [15:0]           win_cnt;
    logic [15:0]           stall_cnt;
`endif

    always #5 clock = ~clock;

    order_25d_seq #(.DSIZE(DSIZE), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sort_vld  (sort_vld),
        .sort_data (sort_data),
        .sort_res  (sort_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef ORDER_SEQ_STAT_EN
        ,
        .win_cnt   (win_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Datapath stand-in: the median word of a launched window appears LAT cycles later.
    logic [DSIZE-1:0] dp_data [64];
    bit               dp_vld  [64];
    int               pc = 0;

    always @(posedge clock) begin
        pc++;
        #1;
        if (dp_vld[pc % 64]) begin
            sort_res = dp_data[pc % 64];
            dp_vld[pc % 64] = 1'b0;
        end else begin
            sort_res = DSIZE'($urandom);
        end
    end

    always @(negedge clock) begin
        if (sort_vld) begin
            dp_data[(pc + LAT) % 64] = sort_data[MED_IDX*DSIZE +: DSIZE];
            dp_vld[(pc + LAT) % 64]  = 1'b1;
        end
    end

    // Stimulus driver, shaped by the main sequence through these knobs.
    int vld_pct   = 0;
    int rdy_pct   = 100;
    bit seq_data  = 1'b1;
    int acc_total = 0;

    always @(posedge clock) begin
        #1;
        in_valid  = ($urandom_range(99) < vld_pct);
        in_data   = seq_data ? DSIZE'(acc_total) : DSIZE'($urandom);
        out_ready = ($urandom_range(99) < rdy_pct);
    end

    // Reference model: pending = 0 loading, 1 window complete awaiting credit, 2 launching.
    int               mc = 0;
    int               m_n = 0;
    int               m_pend = 0;
    int               m_out = 0;
    logic [DSIZE-1:0] m_win [NWIN];
    logic [DSIZE-1:0] m_fifo [$];
    int               pd_due [$];
    logic [DSIZE-1:0] pd_dat [$];
    int               m_win_cnt = 0;
    int               m_stall = 0;
    int               n_launch = 0;
    int               n_pop = 0;
    int               first_fire = -1;
    int               first_ov = -1;
    int               first_pop = -1;
    bit               m_credit;
    bit               m_exp_ov;

    task automatic model_reset(input bit full);
        m_n    = 0;
        m_pend = 0;
        m_out  = 0;
        m_fifo.delete();
        pd_due.delete();
        pd_dat.delete();
        m_win_cnt = 0;
        m_stall   = 0;
        if (full) acc_total = 0;
    endtask

    always @(negedge clock) begin
        mc++;
        if (!rst_n) begin
            model_reset(1'b1);
        end else begin
            while (pd_due.size() > 0 && pd_due[0] <= mc) begin
                m_fifo.push_back(pd_dat.pop_front());
                void'(pd_due.pop_front());
            end
            m_exp_ov = (m_fifo.size() != 0);
            check_eq("in_ready", in_ready, m_pend == 0);
            check_eq("sort_vld", sort_vld, m_pend == 2);
            check_eq("out_valid", out_valid, m_exp_ov);
            if (m_exp_ov) check_eq("out_data", out_data, m_fifo[0]);
            check_eq("busy", busy, (m_n != 0) || (m_pend != 0) || (m_out != 0));
`ifdef ORDER_SEQ_STAT_EN
            check_eq("win_cnt", win_cnt, 32'(m_win_cnt[15:0]));
            check_eq("stall_cnt", stall_cnt, m_stall);
`endif
            if (m_pend == 2) begin
                for (int k = 0; k < NWIN; k++) begin
                    check_eq("sort_word", sort_data[k*DSIZE +: DSIZE], m_win[k]);
                end
            end
            if (out_valid && first_ov < 0) first_ov = mc;
            m_credit = (m_out < FDEPTH);
            if (clr) begin
                model_reset(1'b0);
            end else begin
                if (m_exp_ov && out_ready) begin
                    $display("pop    cyc=%0d data=%0h", mc, m_fifo[0]);
                    if (first_pop < 0) first_pop = int'(m_fifo[0]);
                    void'(m_fifo.pop_front());
                    m_out--;
                    n_pop++;
                    m_win_cnt++;
                end
                if (m_pend == 1 && !m_credit && m_stall < 65535) m_stall++;
                case (m_pend)
                    0: if (in_valid) begin
                        m_win[m_n] = in_data;
                        m_n++;
                        acc_total++;
                        if (m_n == NWIN) begin
                            m_pend = 1;
                            m_n    = 0;
                        end
                    end
                    1: if (m_credit) begin
                        m_pend = 2;
                        m_out++;
                    end
                    default: begin
                        m_pend = 0;
                        n_launch++;
                        if (first_fire < 0) first_fire = mc;
                        pd_due.push_back(mc + LAT + 1);
                        pd_dat.push_back(m_win[MED_IDX]);
                        $display("launch cyc=%0d med=%0h", mc, m_win[MED_IDX]);
                    end
                endcase
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clock);
        #1 clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c0, base_l, base_p, a0, ov_seen;
    logic [DSIZE-1:0] w;

    initial begin
        // Power-on reset values.
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_sort_vld", sort_vld, 0);
        check_eq("rst_sort_data0", sort_data[31:0], 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Stream 0..24 back to back: launch in cycle 27, result visible in cycle 34.
        tick(1);
        c0 = mc + 1;
        first_fire = -1; first_ov = -1; first_pop = -1;
        vld_pct = 100; rdy_pct = 100; seq_data = 1'b1;
        for (int i = 0; i < 80 && (first_ov < 0 || first_pop < 0); i++) tick(1);
        check_eq("t1_fire_cycle", first_fire, c0 + 26);
        check_eq("t1_out_cycle", first_ov, c0 + 33);
        check_eq("t1_result", first_pop, 12);

        // Back-pressure: only FDEPTH launches, then the next window parks in WAIT.
        pulse_clr();
        base_l = n_launch; base_p = n_pop;
        rdy_pct = 0; vld_pct = 100; seq_data = 1'b0;
        tick(200);
        check_eq("t2_launches", n_launch - base_l, FDEPTH);
        check_eq("t2_in_ready_stall", in_ready, 0);
        check_eq("t2_out_valid", out_valid, 1);
`ifdef ORDER_SEQ_STAT_EN
        check_eq("t2_stall_nz", stall_cnt != 16'd0, 1);
`endif
        rdy_pct = 100; vld_pct = 0;
        tick(60);
        check_eq("t2_launches_after", n_launch - base_l, FDEPTH + 1);
        check_eq("t2_pops", n_pop - base_p, FDEPTH + 1);
        check_eq("t2_idle", busy, 0);
`ifdef ORDER_SEQ_STAT_EN
        check_eq("t2_win_cnt", win_cnt, FDEPTH + 1);
`endif

        // Random input gaps and random consumer stalls.
        pulse_clr();
        base_l = n_launch; base_p = n_pop;
        vld_pct = 50; rdy_pct = 70; seq_data = 1'b0;
        for (int i = 0; i < 3000 && (n_launch - base_l) < 6; i++) tick(1);
        check_eq("t3_launches", n_launch - base_l, 6);
        vld_pct = 0; rdy_pct = 100;
        tick(40);
        check_eq("t3_drained", n_pop - base_p, n_launch - base_l);

        // clr three cycles after a launch discards the in-flight result.
        pulse_clr();
        base_p = n_pop;
        vld_pct = 100; rdy_pct = 100; seq_data = 1'b1;
        for (int i = 0; i < 60 && !sort_vld; i++) tick(1);
        check_eq("t4_fired", sort_vld, 1);
        vld_pct = 0;
        repeat (3) @(posedge clock);
        #1 clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
        @(negedge clock);
        #1;
        check_eq("t4_busy_after_clr", busy, 0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (out_valid) ov_seen++;
        end
        check_eq("t4_no_result", ov_seen, 0);
        check_eq("t4_no_pop", n_pop - base_p, 0);
        base_l = n_launch;
        a0 = acc_total;
        vld_pct = 100;
        for (int i = 0; i < 60 && n_launch == base_l; i++) tick(1);
        w = sort_data[0 +: DSIZE];
        check_eq("t4_word0", w, DSIZE'(a0));
        vld_pct = 0;
        tick(20);

        // Asynchronous reset in the middle of loading (idx 10).
        pulse_clr();
        vld_pct = 100; seq_data = 1'b1;
        for (int i = 0; i < 100 && !(m_n == 10 && m_pend == 0); i++) tick(1);
        check_eq("t5_idx10", m_n, 10);
        rst_n = 1'b0;
        #1;
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_sort_vld", sort_vld, 0);
        check_eq("t5_sort_data", sort_data[NWIN*DSIZE-1 -: 32] | sort_data[31:0], 0);
        check_eq("t5_out_valid", out_valid, 0);
        check_eq("t5_out_data", out_data, 0);
        check_eq("t5_busy", busy, 0);
        @(negedge clock);
        @(posedge clock);
        #2 rst_n = 1'b1;
        base_l = n_launch;
        for (int i = 0; i < 60 && n_launch == base_l; i++) tick(1);
        w = sort_data[0 +: DSIZE];
        check_eq("t5_word0", w, 0);
        w = sort_data[MED_IDX*DSIZE +: DSIZE];
        check_eq("t5_word12", w, 12);
        w = sort_data[(NWIN-1)*DSIZE +: DSIZE];
        check_eq("t5_word24", w, 24);
        vld_pct = 0;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/order_25d_seq.md
# order_25d_seq

Sequencer for the 25-word 5x5 sort datapath. Collects a serial stream of 25 samples into a window register and launches the fixed-latency sort datapath with a one-cycle strobe. Tracks in-flight windows with a valid shift chain and captures the selected result word into an output FIFO. Launches are credit-gated so results never overflow the FIFO. Sits between the pixel-window source and the median/order-statistic consumer.

## Interface
- DSIZE, 8, sample width
- LAT, 6, datapath latency in cycles from sort_vld to sort_res valid; ≥1
- FDEPTH, 4, result FIFO depth; power of 2, ≥2
- clock  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort/flush
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid & in_ready
- in_data  in  DSIZE  input sample
- sort_vld  out  1  one-cycle launch strobe to datapath
- sort_data  out  25*DSIZE  window; word k at [k*DSIZE +: DSIZE], word 0 = first accepted sample
- sort_res  in  DSIZE  selected datapath output word, valid LAT cycles after sort_vld
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  DSIZE  result word (FIFO head)
- busy  out  1  high when window partially loaded, waiting, or any result in flight/FIFO

## Operation
- States: LOAD, WAIT, FIRE. Reset/clr state: LOAD, idx=0.
- LOAD: in_ready=1. On accept, write in_data into word idx; idx++. Accept at idx=24 → WAIT, idx→0.
- WAIT: in_ready=0. If credit ok → FIRE, reserving one credit that cycle; else stay.
- Credit ok: fifo_count + inflight < FDEPTH; inflight is a counter +1 on WAIT→FIRE, −1 on capture; same-cycle +1/−1 nets 0.
- FIRE: sort_vld=1 (Moore, exactly one cycle), sort_data stable, in_ready=0; → LOAD.
- sort_data is held from FIRE until the first accept of the next window overwrites word 0.
- Valid chain: LAT-bit shift register, bit 0 loaded with sort_vld each cycle; bit LAT−1 high → write sort_res into FIFO, decrement inflight.
- FIFO: write never blocked (guaranteed by credit); pop on out_valid & out_ready; simultaneous push and pop legal at any fill level including full.
- clr or rst_n: state LOAD, idx 0, valid chain cleared, inflight 0, FIFO emptied; in-flight results discarded; datapath not informed.
- Reset values: in_ready 1 (LOAD), sort_vld 0, sort_data 0, out_valid 0, out_data 0, busy 0.

## Timing
- Minimum window period 27 cycles (25 LOAD + WAIT + FIRE).
- sort_vld high in cycle T → sort_res sampled at edge ending T+LAT → out_valid high in T+LAT+1 if FIFO was empty.
- out_valid, out_data registered from FIFO; no combinational in→out path.
- in_ready depends only on state (no dependency on in_valid).
- With out_ready held 0: exactly FDEPTH windows launch; next window loads fully then holds in WAIT.
- clr has priority over every other event in the same cycle.

## Configuration
- ORDER_SEQ_STAT_EN defined: adds output win_cnt (16 bits), incremented on each FIFO pop, wraps 0xFFFF→0, cleared by rst_n/clr; also adds stall_cnt (16 bits), incremented each cycle in WAIT without credit, saturating at 0xFFFF.
- Not defined: ports absent, no counter logic.

## Structure
- Package order_pkg: NWIN=25, MED_IDX=12, state enum (LOAD/WAIT/FIRE), idx width constant (5 bits).
- One sub-module: order_seq_fifo (synchronous FIFO, DSIZE × FDEPTH, count output, sync flush).

## Test plan
- Stream 0..24 with in_valid=1, out_ready=1, sort_res modelled as word 12 delayed LAT=6 → sort_vld at cycle 27, out_data=12 at cycle 27+7.
- out_ready=0, feed 6 windows → exactly 4 sort_vld pulses; 5th window stalls in WAIT, in_ready=0; raise out_ready → pops 4, 5th launches.
- Random in_valid gaps (50%) → idx advances only on accept; window contents match accepted order.
- clr asserted 3 cycles after a FIRE → no FIFO write from that launch, out_valid stays 0, busy=0 next cycle, new window starts at word 0.
- rst_n pulsed low mid-LOAD (idx=10) → all outputs to reset values asynchronously; next 25 samples form a fresh window.
- With ORDER_SEQ_STAT_EN: 3 windows popped → win_cnt=3; out_ready=0 with full FIFO → stall_cnt counts WAIT cycles.
